// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction-memory request/acknowledge bundle.
//
// Signals:
//   imemReq  - fetch request, driven by the fetch unit
//   imemAddr - fetch address, held stable while imemReq=1 and imemAck=0
//   imemAck  - memory accepted the request; imemData is valid this cycle
//   imemData - 32-bit instruction word
//
// Modports: master = fetch unit side, slave = instruction memory side.
interface inst_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              imemReq;
   logic [ADDR_W-1:0] imemAddr;
   logic              imemAck;
   logic [31:0]       imemData;

   modport master (output imemReq, output imemAddr, input imemAck, input imemData);
   modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage feeding the control unit.
//
// Owns PC/NPC, fetches instructions over a req/ack memory handshake into the
// instruction register (IR) and exposes the decoded IR fields, the immediate
// and the branch target.
//
// Ports:
//   clk, rstN                 - clock (rising edge), async active-low reset
//   ldPC, clrPC               - PC update / synchronous PC clear (clrPC wins)
//   isRet, isBranchTaken      - next-PC select (return has priority)
//   retAddr                   - return address
//   ldInst, clrInst           - fetch enable / synchronous IR + FSM clear
//   imem                      - instruction memory handshake (master side)
//   instValid                 - IR holds the instruction for the current PC
//   opcode, iOrReg, rd, rs1, rs2, modifier, imm - decoded IR fields
//   npc                       - registered PC + INST_BYTES
//   brnchTarget               - PC + (sign-extended IR[26:0] << 2)
//
// Optional build macro IFU_IMM_EXT_EN: when defined, imm is built from IR[15:0]
// according to modifier; otherwise imm is IR[17:0] zero-extended.
module inst_fetch_unit #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
   parameter int                INST_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  ldPC,
   input  logic                  clrPC,
   input  logic                  ldInst,
   input  logic                  clrInst,
   input  logic                  isBranchTaken,
   input  logic                  isRet,
   input  logic [ADDR_W-1:0]     retAddr,
   inst_fetch_unit_if.master     imem,
   output logic                  instValid,
   output logic [4:0]            opcode,
   output logic                  iOrReg,
   output logic [3:0]            rd,
   output logic [3:0]            rs1,
   output logic [3:0]            rs2,
   output logic [1:0]            modifier,
   output logic [31:0]           imm,
   output logic [ADDR_W-1:0]     npc,
   output logic [ADDR_W-1:0]     brnchTarget
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [ADDR_W-1:0] pc_r, npc_r, pc_nxt_s;
   logic [ADDR_W-1:0] sext_s, brnch_s;
   logic              pc_chg_s;
   logic              req_r, req_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [31:0]       ir_r, ir_nxt_s;
   logic              valid_r, valid_nxt_s;
   logic              stale_r, stale_nxt_s;

   // Immediate extraction from the instruction word.
   function automatic logic [31:0] imm_f(input logic [31:0] ir);
`ifdef IFU_IMM_EXT_EN
      case (ir[17:16])
         2'b00:   imm_f = {{16{ir[15]}}, ir[15:0]};
         2'b01:   imm_f = {16'h0000, ir[15:0]};
         2'b10:   imm_f = {ir[15:0], 16'h0000};
         2'b11:   imm_f = {{16{ir[15]}}, ir[15:0]};
         default: imm_f = {{16{ir[15]}}, ir[15:0]};
      endcase
`else
      imm_f = {14'd0, ir[17:0]};
`endif
   endfunction

   // Branch target and next-PC selection; clear beats load, return beats branch.
   always_comb begin
      sext_s   = {{(ADDR_W-27){ir_r[26]}}, ir_r[26:0]};
      brnch_s  = pc_r + {sext_s[ADDR_W-3:0], 2'b00};
      pc_chg_s = clrPC | ldPC;
      if (clrPC) begin
         pc_nxt_s = RESET_PC;
      end else if (ldPC) begin
         if (isRet) begin
            pc_nxt_s = retAddr;
         end else if (isBranchTaken) begin
            pc_nxt_s = brnch_s;
         end else begin
            pc_nxt_s = npc_r;
         end
      end else begin
         pc_nxt_s = pc_r;
      end
   end

   // Fetch FSM next-state logic. A PC change while a request is outstanding
   // marks it stale so the returning word is dropped and the fetch reissued.
   always_comb begin
      state_nxt_s = state_r;
      req_nxt_s   = req_r;
      addr_nxt_s  = addr_r;
      ir_nxt_s    = ir_r;
      valid_nxt_s = valid_r;
      stale_nxt_s = stale_r;
      if (clrInst) begin
         state_nxt_s = S_IDLE;
         req_nxt_s   = 1'b0;
         ir_nxt_s    = 32'h0000_0000;
         valid_nxt_s = 1'b0;
         stale_nxt_s = 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (ldInst && !valid_r) begin
                  state_nxt_s = S_REQ;
                  req_nxt_s   = 1'b1;
                  addr_nxt_s  = pc_nxt_s;
                  stale_nxt_s = 1'b0;
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end
            S_REQ, S_WAIT: begin
               if (imem.imemAck) begin
                  if (stale_r || pc_chg_s) begin
                     valid_nxt_s = 1'b0;
                     stale_nxt_s = 1'b0;
                     if (ldInst) begin
                        state_nxt_s = S_REQ;
                        req_nxt_s   = 1'b1;
                        addr_nxt_s  = pc_nxt_s;
                     end else begin
                        state_nxt_s = S_IDLE;
                        req_nxt_s   = 1'b0;
                     end
                  end else begin
                     state_nxt_s = S_DONE;
                     req_nxt_s   = 1'b0;
                     ir_nxt_s    = imem.imemData;
                     valid_nxt_s = 1'b1;
                  end
               end else begin
                  // Request and address held until the memory acknowledges.
                  state_nxt_s = S_WAIT;
                  stale_nxt_s = stale_r | pc_chg_s;
               end
            end
            S_DONE: begin
               if (pc_chg_s) begin
                  state_nxt_s = S_IDLE;
                  valid_nxt_s = 1'b0;
               end else begin
                  state_nxt_s = S_DONE;
                  valid_nxt_s = 1'b1;
               end
            end
            default: begin
               state_nxt_s = S_IDLE;
               req_nxt_s   = 1'b0;
               valid_nxt_s = 1'b0;
               stale_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // State, PC/NPC and fetch registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_r <= S_IDLE;
         pc_r    <= RESET_PC;
         npc_r   <= RESET_PC + ADDR_W'(INST_BYTES);
         req_r   <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         ir_r    <= 32'h0000_0000;
         valid_r <= 1'b0;
         stale_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         // Follows PC one cycle later; wraps at ADDR_W.
         npc_r   <= pc_r + ADDR_W'(INST_BYTES);
         req_r   <= req_nxt_s;
         addr_r  <= addr_nxt_s;
         ir_r    <= ir_nxt_s;
         valid_r <= valid_nxt_s;
         stale_r <= stale_nxt_s;
      end
   end

   assign imem.imemReq  = req_r;
   assign imem.imemAddr = addr_r;
   assign instValid     = valid_r;
   assign npc           = npc_r;
   assign brnchTarget   = brnch_s;
   assign opcode        = ir_r[31:27];
   assign iOrReg        = ir_r[26];
   assign rd            = ir_r[25:22];
   assign rs1           = ir_r[21:18];
   assign rs2           = ir_r[17:14];
   assign modifier      = ir_r[17:16];
   assign imm           = imm_f(ir_r);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed bench for inst_fetch_unit with hand-computed
// expected values. Inputs change and outputs are sampled 1 time unit after
// each rising clock edge.
module tb_inst_fetch_unit;
   logic        clk = 1'b0;
   logic        rstN;
   logic        ldPC, clrPC, ldInst, clrInst, isBranchTaken, isRet;
   logic [31:0] retAddr;
   logic        instValid, iOrReg;
   logic [4:0]  opcode;
   logic [3:0]  rd, rs1, rs2;
   logic [1:0]  modifier;
   logic [31:0] imm, npc, brnchTarget;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] imm_exp;

   inst_fetch_unit_if #(.ADDR_W(32)) imem ();

   inst_fetch_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rstN(rstN), .ldPC(ldPC), .clrPC(clrPC), .ldInst(ldInst),
      .clrInst(clrInst), .isBranchTaken(isBranchTaken), .isRet(isRet),
      .retAddr(retAddr), .imem(imem), .instValid(instValid), .opcode(opcode),
      .iOrReg(iOrReg), .rd(rd), .rs1(rs1), .rs2(rs2), .modifier(modifier),
      .imm(imm), .npc(npc), .brnchTarget(brnchTarget)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstN = 1'b0; ldPC = 1'b0; clrPC = 1'b0; ldInst = 1'b0; clrInst = 1'b0;
      isBranchTaken = 1'b0; isRet = 1'b0; retAddr = 32'h0;
      imem.imemAck = 1'b0; imem.imemData = 32'h0;
      tick(); tick();
      check_eq("rst_valid", {31'd0, instValid}, 32'd0);
      check_eq("rst_req", {31'd0, imem.imemReq}, 32'd0);
      check_eq("rst_addr", imem.imemAddr, 32'h0);
      check_eq("rst_npc", npc, 32'h4);
      check_eq("rst_opcode", {27'd0, opcode}, 32'd0);
      rstN = 1'b1;

      // Same-cycle ack
      ldInst = 1'b1;
      tick();
      check_eq("t1_req", {31'd0, imem.imemReq}, 32'd1);
      check_eq("t1_addr", imem.imemAddr, 32'h0);
      imem.imemAck = 1'b1; imem.imemData = 32'h0A40_0005;
      tick();
      imem.imemAck = 1'b0;
      check_eq("t1_valid", {31'd0, instValid}, 32'd1);
      check_eq("t1_opcode", {27'd0, opcode}, 32'd1);
      check_eq("t1_iorreg", {31'd0, iOrReg}, 32'd0);
      check_eq("t1_rd", {28'd0, rd}, 32'd9);
      check_eq("t1_rs1", {28'd0, rs1}, 32'd0);
      check_eq("t1_npc", npc, 32'h4);
      check_eq("t1_imm", imm, 32'h5);
      check_eq("t1_req_drop", {31'd0, imem.imemReq}, 32'd0);

      // Delayed ack: request and address stable while waiting
      clrInst = 1'b1;
      tick();
      clrInst = 1'b0;
      check_eq("t2_clr_valid", {31'd0, instValid}, 32'd0);
      check_eq("t2_clr_opcode", {27'd0, opcode}, 32'd0);
      tick();
      check_eq("t2_req", {31'd0, imem.imemReq}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t2_wait_req", {31'd0, imem.imemReq}, 32'd1);
         check_eq("t2_wait_addr", imem.imemAddr, 32'h0);
         check_eq("t2_wait_valid", {31'd0, instValid}, 32'd0);
      end
      imem.imemAck = 1'b1; imem.imemData = 32'h1122_3344;
      tick();
      imem.imemAck = 1'b0;
      check_eq("t2_valid", {31'd0, instValid}, 32'd1);
      check_eq("t2_opcode", {27'd0, opcode}, 32'd2);
      check_eq("t2_rd", {28'd0, rd}, 32'd4);

      // Move PC to 0x20 via return, fetch a branch instruction there
      retAddr = 32'h20; isRet = 1'b1; ldPC = 1'b1;
      tick();
      ldPC = 1'b0; isRet = 1'b0;
      check_eq("t3_ret_valid", {31'd0, instValid}, 32'd0);
      tick();
      check_eq("t3_addr20", imem.imemAddr, 32'h20);
      check_eq("t3_npc24", npc, 32'h24);
      imem.imemAck = 1'b1; imem.imemData = 32'h8000_0010;
      tick();
      imem.imemAck = 1'b0;
      check_eq("t3_opcode", {27'd0, opcode}, 32'd16);
      check_eq("t3_brtgt", brnchTarget, 32'h60);
      isBranchTaken = 1'b1; ldPC = 1'b1;
      tick();
      isBranchTaken = 1'b0; ldPC = 1'b0;
      check_eq("t3_br_valid", {31'd0, instValid}, 32'd0);
      tick();
      check_eq("t3_addr60", imem.imemAddr, 32'h60);
      check_eq("t3_req60", {31'd0, imem.imemReq}, 32'd1);

      // Immediate decode
      imem.imemAck = 1'b1; imem.imemData = 32'h0C02_1234;
      tick();
      imem.imemAck = 1'b0;
`ifdef IFU_IMM_EXT_EN
      imm_exp = 32'h1234_0000;
`else
      imm_exp = 32'h0002_1234;
`endif
      check_eq("imm_iorreg", {31'd0, iOrReg}, 32'd1);
      check_eq("imm_modifier", {30'd0, modifier}, 32'd2);
      check_eq("imm_value", imm, imm_exp);

      // Return has priority over branch
      retAddr = 32'h100; isRet = 1'b1; isBranchTaken = 1'b1; ldPC = 1'b1;
      tick();
      isRet = 1'b0; isBranchTaken = 1'b0; ldPC = 1'b0;
      tick();
      check_eq("t4_addr100", imem.imemAddr, 32'h100);
      check_eq("t4_npc104", npc, 32'h104);

      // clrPC beats ldPC; PC changes while waiting make the fetch stale
      clrPC = 1'b1; ldPC = 1'b1; isRet = 1'b1; retAddr = 32'h200;
      tick();
      clrPC = 1'b0; ldPC = 1'b0; isRet = 1'b0;
      check_eq("t5_hold_req", {31'd0, imem.imemReq}, 32'd1);
      check_eq("t5_hold_addr", imem.imemAddr, 32'h100);
      tick();
      check_eq("t5_clrpc_npc", npc, 32'h4);
      ldPC = 1'b1;
      tick();
      ldPC = 1'b0;
      check_eq("t5_hold_addr2", imem.imemAddr, 32'h100);
      imem.imemAck = 1'b1; imem.imemData = 32'hDEAD_0000;
      tick();
      imem.imemAck = 1'b0;
      check_eq("t5_stale_valid", {31'd0, instValid}, 32'd0);
      check_eq("t5_reissue_req", {31'd0, imem.imemReq}, 32'd1);
      check_eq("t5_reissue_addr", imem.imemAddr, 32'h4);
      imem.imemAck = 1'b1; imem.imemData = 32'h1800_0000;
      tick();
      imem.imemAck = 1'b0;
      check_eq("t5_valid", {31'd0, instValid}, 32'd1);
      check_eq("t5_opcode", {27'd0, opcode}, 32'd3);

      // PC wrap-around
      retAddr = 32'hFFFF_FFFC; isRet = 1'b1; ldPC = 1'b1;
      tick();
      isRet = 1'b0; ldPC = 1'b0;
      tick();
      check_eq("wrap_npc", npc, 32'h0);
      check_eq("wrap_addr", imem.imemAddr, 32'hFFFF_FFFC);

      // clrInst and ack on the same edge: clrInst wins; late ack ignored
      clrInst = 1'b1; imem.imemAck = 1'b1; imem.imemData = 32'h1800_0000;
      tick();
      clrInst = 1'b0; imem.imemAck = 1'b0; ldInst = 1'b0;
      check_eq("clr_valid", {31'd0, instValid}, 32'd0);
      check_eq("clr_opcode", {27'd0, opcode}, 32'd0);
      check_eq("clr_req", {31'd0, imem.imemReq}, 32'd0);
      imem.imemAck = 1'b1;
      tick();
      imem.imemAck = 1'b0;
      check_eq("late_valid", {31'd0, instValid}, 32'd0);
      check_eq("late_opcode", {27'd0, opcode}, 32'd0);
      check_eq("late_req", {31'd0, imem.imemReq}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit.
- Owns PC/NPC, fetches 32-bit instructions over a req/ack instruction-memory handshake, and latches them into the instruction register (IR).
- Drives the decoded fields the control unit consumes: opcode, iOrReg, modifier.
- Also drives register indices, the immediate and the branch target.
- Applies the control unit's PC-update commands, covering sequential, taken branch and return.

Parameters:
- ADDR_W, 32, PC / memory address width.
- RESET_PC, 0, PC value after reset or clrPC.
- INST_BYTES, 4, NPC increment.

Ports:
- clk  in  1  clock, rising-edge.
- rstN  in  1  asynchronous active-low reset.
- ldPC  in  1  level; PC update on every clk edge while high (control unit pulses it one cycle).
- clrPC  in  1  sync clear of PC to RESET_PC; overrides ldPC.
- ldInst  in  1  level; enables fetch engine.
- clrInst  in  1  sync clear of IR, instValid, FSM to IDLE.
- isBranchTaken  in  1  select branch target on PC update.
- isRet  in  1  select retAddr on PC update (priority over branch target).
- retAddr  in  ADDR_W  return address from register file (ra).
- imemReq  out  1  fetch request.
- imemAddr  out  ADDR_W  fetch address.
- imemAck  in  1  memory accepted request, imemData valid this cycle.
- imemData  in  32  instruction word.
- instValid  out  1  IR holds a fetched instruction for the current PC.
- opcode  out  5  IR[31:27].
- iOrReg  out  1  IR[26].
- rd  out  4  IR[25:22].
- rs1  out  4  IR[21:18].
- rs2  out  4  IR[17:14].
- modifier  out  2  IR[17:16].
- imm  out  32  immediate (see Optional Feature).
- npc  out  ADDR_W  PC+INST_BYTES, registered.
- brnchTarget  out  ADDR_W  PC + (sign-extended IR[26:0] << 2), combinational from PC/IR.

Behaviour:
- Reset (rstN=0, async):
  - PC=RESET_PC, npc=RESET_PC+INST_BYTES.
  - IR=0, instValid=0, imemReq=0, imemAddr=0.
  - FSM=IDLE.
- Decoded outputs are combinational from IR; IR=0 decodes as opcode 0.
- PC update on clk edge when ldPC=1 and clrPC=0. Next PC by priority:
  1. isRet → retAddr.
  2. isBranchTaken → brnchTarget.
  3. Otherwise → npc.
- npc is recomputed the cycle after any PC change, with ADDR_W wrap-around (PC all-ones+4 wraps, no flag).
- Any PC change forces instValid=0 the same edge. If a fetch is outstanding, its returning data is discarded (stale) and the FSM refetches.
- FSM states:
  - IDLE: if ldInst=1 and instValid=0 → REQ.
  - REQ: imemReq=1, imemAddr=PC. On imemAck same cycle → IR=imemData, instValid=1 → DONE. Otherwise → WAIT.
  - WAIT: imemReq held 1, imemAddr held stable. On imemAck → latch → DONE. If PC changed meanwhile → mark stale; drop data on ack, → REQ.
  - DONE: instValid=1; stay until PC changes or clrInst → IDLE.
- imemAddr/imemReq must not change while imemReq=1 and imemAck=0.
- Fetch latency: minimum 1 cycle from REQ entry to instValid (ack in REQ cycle); unbounded wait otherwise.
- clrInst mid-fetch:
  - Drop imemReq next edge; IR cleared → IDLE.
  - A late ack after the drop is ignored.
- clrPC with ldPC: clrPC wins.
- clrInst and ack same edge: clrInst wins.
- ldInst=0: no new request issued; an outstanding request completes normally.
- isRet and isBranchTaken both 1: retAddr used.

Optional Feature:
- Macro IFU_IMM_EXT_EN.
- When defined, imm is derived from IR[15:0] by modifier:
  - 00 → sign-extend.
  - 01 → zero-extend.
  - 10 → IR[15:0] << 16.
  - 11 → sign-extend.
- When undefined, imm = zero-extended IR[17:0], and the modifier output is still driven.

Test Plan:
- Reset then ldInst=1, memory acks in same cycle with 32'h0A400005 → instValid=1 next edge, opcode=1, iOrReg=0, rd=9, npc=4.
- Ack delayed 3 cycles → imemReq=1 and imemAddr=0 stable all 3 cycles, IR loads on ack edge only.
- IR=32'h8000_0010 at PC=0x20, isBranchTaken=1, ldPC pulse → PC=0x60, instValid=0, new fetch at 0x60.
- isRet=1 and isBranchTaken=1, retAddr=0x100, ldPC → PC=0x100.
- ldPC during WAIT (PC 0→4) → ack data for addr 0 discarded, request reissued at 4, IR gets addr-4 word.
- With IFU_IMM_EXT_EN: iOrReg=1, modifier=10, IR[15:0]=0x1234 → imm=0x12340000. Without it: imm=0x21234.
